// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths, decode encodings and state encoding for the
// fetch-side program-counter sequencer.
package pc_seq_pkg;

   localparam int PC_W  = 36;
   localparam int CNT_W = 3;   // flush bubble counter (FLUSH_CYCLES 1..7)

   localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      BJ_NONE   = 2'b00,
      BJ_JUMP   = 2'b01,
      BJ_BRANCH = 2'b10
   } bj_e;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      FLUSH = 2'b01,
      HALT  = 2'b10
   } seq_state_e;

   // A resolved jump/branch only redirects when it leaves the sequential
   // path; a not-taken branch reports its own PC and the reserved code is
   // treated as no control transfer.
   function automatic logic is_redirect(
      input logic            valid,
      input logic [1:0]      bj,
      input logic [PC_W-1:0] pc,
      input logic [PC_W-1:0] target
   );
      return valid && (bj == BJ_JUMP || bj == BJ_BRANCH) && (target != pc);
   endfunction

endpackage

// File: rtl/pc_seq_perf.sv
// pc_seq_perf: saturating redirect and stall-cycle event counters for the
// PC sequencer. Only instantiated when PC_SEQ_PERF_EN is defined.
module pc_seq_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_inc,
   input  logic        stall_inc,
   output logic [31:0] redirects,
   output logic [31:0] stall_cycles
);

   logic [31:0] redirects_reg;
   logic [31:0] stall_cycles_reg;

   // Count events, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirects_reg    <= '0;
         stall_cycles_reg <= '0;
      end else begin
         if (redirect_inc && redirects_reg != 32'hFFFF_FFFF)
            redirects_reg <= redirects_reg + 32'd1;
         if (stall_inc && stall_cycles_reg != 32'hFFFF_FFFF)
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
   end

   assign redirects    = redirects_reg;
   assign stall_cycles = stall_cycles_reg;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC. Advances sequentially, applies
// execute-stage redirects followed by FLUSH_CYCLES flush bubbles, and
// honours stall and halt/resume.
// Optional feature macro: PC_SEQ_PERF_EN adds saturating perf counters.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            halt,
   input  logic            resume,
   input  logic            ex_valid,
   input  logic [1:0]      ex_branch_jump,
   input  logic [PC_W-1:0] ex_pc,
   input  logic [PC_W-1:0] ex_target,
   output logic [PC_W-1:0] fetch_pc,
   output logic            fetch_valid,
   output logic            flush,
   output logic            halted
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [31:0]     perf_redirects,
   output logic [31:0]     perf_stall_cycles
`endif
);

   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   seq_state_e       state_reg, state_next;
   logic [PC_W-1:0]  pc_reg, pc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             redirect;

   assign redirect = is_redirect(ex_valid, ex_branch_jump, ex_pc, ex_target);

   // State, PC and flush counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state/PC selection; outputs decode from state and stall only.
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      cnt_next    = cnt_reg;
      fetch_valid = 1'b0;
      flush       = 1'b0;
      halted      = 1'b0;
      case (state_reg)
         RUN: begin
            fetch_valid = !stall;
            if (redirect) begin
               pc_next    = ex_target;
               cnt_next   = FLUSH_LOAD;
               state_next = FLUSH;
            end else if (halt) begin
               state_next = HALT;
            end else if (!stall) begin
               pc_next = pc_reg + PC_ONE;   // silent wrap at 2^36
            end
         end
         FLUSH: begin
            // EX only carries flushed bubbles here, so its inputs are ignored.
            flush = 1'b1;
            if (cnt_reg == '0)
               state_next = RUN;
            else
               cnt_next = cnt_reg - CNT_ONE;
         end
         HALT: begin
            halted = 1'b1;
            // An older branch resolving after the halt decode still wins.
            if (redirect) begin
               pc_next    = ex_target;
               cnt_next   = FLUSH_LOAD;
               state_next = FLUSH;
            end else if (resume && !halt) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   assign fetch_pc = pc_reg;

`ifdef PC_SEQ_PERF_EN
   logic redirect_taken;
   logic stall_count;

   assign redirect_taken = redirect && (state_reg == RUN || state_reg == HALT);
   assign stall_count    = (state_reg == RUN) && stall && !redirect;

   pc_seq_perf u_perf (
      .clk          (clk),
      .rst          (rst),
      .redirect_inc (redirect_taken),
      .stall_inc    (stall_count),
      .redirects    (perf_redirects),
      .stall_cycles (perf_stall_cycles)
   );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer with hand-computed
// expectations. Inputs change just after the falling edge; outputs are
// checked 1 time unit later, well away from the rising edge.
module tb_pc_sequencer;
   import pc_seq_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall, halt, resume, ex_valid;
   logic [1:0]      ex_branch_jump;
   logic [PC_W-1:0] ex_pc, ex_target;
   logic [PC_W-1:0] fetch_pc;
   logic            fetch_valid, flush, halted;
`ifdef PC_SEQ_PERF_EN
   logic [31:0]     perf_redirects, perf_stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   pc_sequencer #(.RESET_PC(36'h100), .FLUSH_CYCLES(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .halt           (halt),
      .resume         (resume),
      .ex_valid       (ex_valid),
      .ex_branch_jump (ex_branch_jump),
      .ex_pc          (ex_pc),
      .ex_target      (ex_target),
      .fetch_pc       (fetch_pc),
      .fetch_valid    (fetch_valid),
      .flush          (flush),
      .halted         (halted)
`ifdef PC_SEQ_PERF_EN
      ,
      .perf_redirects    (perf_redirects),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Hard bound on run time in case something wedges.
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_ex(input logic v, input logic [1:0] bj, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
      ex_valid       = v;
      ex_branch_jump = bj;
      ex_pc          = pc;
      ex_target      = tgt;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0;
      set_ex(1'b0, 2'b00, '0, '0);

      // Reset state
      tick(); tick(); #1;
      check_value("rst_pc", 64'(fetch_pc), 64'h100);
      check_value("rst_flush", 64'(flush), 64'h0);
      check_value("rst_halted", 64'(halted), 64'h0);
`ifdef PC_SEQ_PERF_EN
      check_value("rst_perf_redir", 64'(perf_redirects), 64'h0);
      check_value("rst_perf_stall", 64'(perf_stall_cycles), 64'h0);
`endif
      tick(); rst = 1'b0; #1;
      check_value("seq0_pc", 64'(fetch_pc), 64'h100);
      check_value("seq0_valid", 64'(fetch_valid), 64'h1);
      tick(); #1;
      check_value("seq1_pc", 64'(fetch_pc), 64'h101);

      // Jump 0x104 -> 0x200 in cycle N
      tick(); set_ex(1'b1, 2'b01, 36'h104, 36'h200); #1;
      check_value("jmpN_pc", 64'(fetch_pc), 64'h102);
      check_value("jmpN_flush", 64'(flush), 64'h0);
      tick(); set_ex(1'b0, 2'b00, '0, '0); #1;
      check_value("jmpN1_flush", 64'(flush), 64'h1);
      check_value("jmpN1_valid", 64'(fetch_valid), 64'h0);
      check_value("jmpN1_pc", 64'(fetch_pc), 64'h200);
      tick(); #1;
      check_value("jmpN2_flush", 64'(flush), 64'h1);
      check_value("jmpN2_valid", 64'(fetch_valid), 64'h0);
      tick(); #1;
      check_value("jmpN3_flush", 64'(flush), 64'h0);
      check_value("jmpN3_valid", 64'(fetch_valid), 64'h1);
      check_value("jmpN3_pc", 64'(fetch_pc), 64'h200);

      // Not-taken branch, then reserved code: neither redirects
      tick(); set_ex(1'b1, 2'b10, 36'h150, 36'h150); #1;
      check_value("ntb_pc", 64'(fetch_pc), 64'h201);
      tick(); set_ex(1'b1, 2'b11, 36'h1, 36'h300); #1;
      check_value("ntb_flush", 64'(flush), 64'h0);
      check_value("ntb_pc_next", 64'(fetch_pc), 64'h202);
      tick(); set_ex(1'b0, 2'b00, '0, '0); #1;
      check_value("rsv_flush", 64'(flush), 64'h0);
      check_value("rsv_pc", 64'(fetch_pc), 64'h203);

      // Redirect to 0x110, then stall 3 cycles there
      tick(); set_ex(1'b1, 2'b01, 36'h0, 36'h110); #1;
      tick(); set_ex(1'b0, 2'b00, '0, '0); #1;
      tick(); #1;
      tick(); stall = 1'b1; #1;
      check_value("stall1_pc", 64'(fetch_pc), 64'h110);
      check_value("stall1_valid", 64'(fetch_valid), 64'h0);
      tick(); #1;
      check_value("stall2_pc", 64'(fetch_pc), 64'h110);
      check_value("stall2_valid", 64'(fetch_valid), 64'h0);
      tick(); #1;
      check_value("stall3_pc", 64'(fetch_pc), 64'h110);
      check_value("stall3_valid", 64'(fetch_valid), 64'h0);
`ifdef PC_SEQ_PERF_EN
      // Stalls so far: the two completed stall cycles
      check_value("perf_stall2", 64'(perf_stall_cycles), 64'h2);
`endif
      tick(); stall = 1'b0; #1;
      check_value("unstall_pc", 64'(fetch_pc), 64'h110);
      check_value("unstall_valid", 64'(fetch_valid), 64'h1);
      tick(); #1;
      check_value("unstall_pc1", 64'(fetch_pc), 64'h111);

      // Same-cycle redirect beats stall
      tick(); stall = 1'b1; set_ex(1'b1, 2'b01, 36'h111, 36'h300); #1;
      check_value("rds_valid", 64'(fetch_valid), 64'h0);
      tick(); stall = 1'b0; set_ex(1'b0, 2'b00, '0, '0); #1;
      check_value("rds_flush", 64'(flush), 64'h1);
      check_value("rds_pc", 64'(fetch_pc), 64'h300);
      tick(); #1;
      tick(); #1;
      check_value("rds_done_valid", 64'(fetch_valid), 64'h1);
      check_value("rds_done_pc", 64'(fetch_pc), 64'h300);

      // Halt, then an older branch resolves in HALT
      tick(); halt = 1'b1; #1;
      check_value("hr_pre_halted", 64'(halted), 64'h0);
      tick(); halt = 1'b0; set_ex(1'b1, 2'b10, 36'h50, 36'h400); #1;
      check_value("hr_halted", 64'(halted), 64'h1);
      check_value("hr_valid", 64'(fetch_valid), 64'h0);
      check_value("hr_pc", 64'(fetch_pc), 64'h301);
      tick(); set_ex(1'b0, 2'b00, '0, '0); #1;
      check_value("hr_flush", 64'(flush), 64'h1);
      check_value("hr_exit_halted", 64'(halted), 64'h0);
      check_value("hr_tgt_pc", 64'(fetch_pc), 64'h400);
      tick(); #1;
      tick(); #1;
      check_value("hr_run_valid", 64'(fetch_valid), 64'h1);
      check_value("hr_run_pc", 64'(fetch_pc), 64'h400);

      // Halt, halt+resume together stays halted, then resume
      tick(); #1;
      tick(); halt = 1'b1; #1;
      check_value("h_pc", 64'(fetch_pc), 64'h402);
      tick(); halt = 1'b1; resume = 1'b1; #1;
      check_value("h_halted", 64'(halted), 64'h1);
      tick(); halt = 1'b0; resume = 1'b0; #1;
      check_value("hboth_halted", 64'(halted), 64'h1);
      tick(); #1;
      tick(); #1;
      tick(); #1;
      tick(); resume = 1'b1; #1;
      check_value("hwait_halted", 64'(halted), 64'h1);
      tick(); resume = 1'b0; #1;
      check_value("res_halted", 64'(halted), 64'h0);
      check_value("res_valid", 64'(fetch_valid), 64'h1);
      check_value("res_pc", 64'(fetch_pc), 64'h402);
      tick(); #1;
      check_value("res_pc1", 64'(fetch_pc), 64'h403);

      // PC wrap at 2^36
      tick(); set_ex(1'b1, 2'b01, 36'h404, 36'hF_FFFF_FFFF); #1;
      tick(); set_ex(1'b0, 2'b00, '0, '0); #1;
      tick(); #1;
      tick(); #1;
      check_value("wrap_top_pc", 64'(fetch_pc), 64'hF_FFFF_FFFF);
      check_value("wrap_top_valid", 64'(fetch_valid), 64'h1);
      tick(); #1;
      check_value("wrap_zero_pc", 64'(fetch_pc), 64'h0);
      tick(); #1;
      check_value("wrap_one_pc", 64'(fetch_pc), 64'h1);

      // Reset mid-FLUSH
      tick(); set_ex(1'b1, 2'b01, 36'h2, 36'h500); #1;
      tick(); set_ex(1'b0, 2'b00, '0, '0); rst = 1'b1; #1;
      check_value("rstf_flush_pre", 64'(flush), 64'h1);
      tick(); rst = 1'b0; #1;
      check_value("rstf_flush", 64'(flush), 64'h0);
      check_value("rstf_pc", 64'(fetch_pc), 64'h100);
      check_value("rstf_valid", 64'(fetch_valid), 64'h1);

      // Reset mid-HALT
      tick(); halt = 1'b1; #1;
      tick(); halt = 1'b0; rst = 1'b1; #1;
      check_value("rsth_halted_pre", 64'(halted), 64'h1);
      tick(); rst = 1'b0; #1;
      check_value("rsth_halted", 64'(halted), 64'h0);
      check_value("rsth_pc", 64'(fetch_pc), 64'h100);

`ifdef PC_SEQ_PERF_EN
      // Saturation of the redirect counter
      check_value("perf_rst_redir", 64'(perf_redirects), 64'h0);
      tick();
      force dut.u_perf.redirects_reg = 32'hFFFF_FFFF;
      #1;
      release dut.u_perf.redirects_reg;
      set_ex(1'b1, 2'b01, 36'h0, 36'h600); #1;
      tick(); set_ex(1'b0, 2'b00, '0, '0); #1;
      check_value("perf_sat", 64'(perf_redirects), 64'hFFFF_FFFF);
      check_value("perf_sat_pc", 64'(fetch_pc), 64'h600);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program-counter controller for the 36-bit core. Owns the architectural fetch PC, advances it sequentially, and applies redirects resolved by the execute-stage branch/jump decoder. Issues flush bubbles to IF/ID after a redirect, and honours hazard stalls and halt/resume. Sits between the execute-stage branch/jump decoder and the instruction-fetch stage.

## Interface
- `RESET_PC`, 36'h0, first fetch address after reset
- `FLUSH_CYCLES`, 2, bubble cycles after a redirect (legal range 1..7)

Reset is synchronous and active-high on `rst`, sampled on the rising edge of `clk`.

- `clk` in 1: sole clock
- `rst` in 1: synchronous, active-high reset
- `stall` in 1: hazard unit holds fetch
- `halt` in 1: halt instruction decoded
- `resume` in 1: external restart from HALT
- `ex_valid` in 1: EX holds a valid instruction
- `ex_branch_jump` in 2: 00 none, 01 jump, 10 conditional branch, 11 reserved (treated as none)
- `ex_pc` in 36: PC value presented to the decoder's `pc` input
- `ex_target` in 36: decoder `pc_next` output
- `fetch_pc` out 36: address to fetch this cycle
- `fetch_valid` out 1: `fetch_pc` is a real fetch
- `flush` out 1: kill IF/ID contents this cycle
- `halted` out 1: in HALT state

## Operation
- Redirect condition: `ex_valid` & `ex_branch_jump` ∈ {01,10} & `ex_target` != `ex_pc`. A not-taken branch returns `ex_pc` and is not a redirect.
- States:
  - RUN: `fetch_valid` = !`stall`.
  - FLUSH: `fetch_valid` = 0, `flush` = 1. Down-counter loaded with `FLUSH_CYCLES`-1.
  - HALT: `fetch_valid` = 0, `halted` = 1.
- Priority in RUN: redirect > halt > stall > sequential.
  - Redirect: `fetch_pc` <= `ex_target`; go to FLUSH.
  - Halt: hold `fetch_pc`; go to HALT.
  - Stall: hold `fetch_pc`.
  - Otherwise: `fetch_pc` <= `fetch_pc` + 1, mod 2^36. Wrap from 36'hF_FFFF_FFFF to 0 is silent.
- FLUSH: counter decrements each cycle. Go to RUN when it reaches 0. `ex_*`, `halt` and `stall` are ignored because EX holds only flushed bubbles.
- HALT:
  - Redirect in HALT is applied: load target, go to FLUSH. This covers an older branch that resolves after the halt decode.
  - Otherwise `resume` goes to RUN with `fetch_pc` unchanged.
  - `halt` and `resume` together: stay in HALT.

## Timing
- Reset values: `fetch_pc` = `RESET_PC`, state RUN, `fetch_valid` = 1 in the first cycle after `rst` deasserts, `flush` = 0, `halted` = 0, flush counter 0, perf counters 0.
- `fetch_pc` and state are registered. `fetch_valid`, `flush` and `halted` decode from state and `stall` only.
- Redirect seen in cycle N:
  - `flush` = 1 and `fetch_valid` = 0 in cycles N+1 .. N+`FLUSH_CYCLES`.
  - `fetch_pc` = `ex_target` from cycle N+1.
  - First valid fetch at target in cycle N+`FLUSH_CYCLES`+1.
- Stall: zero-latency hold; `fetch_pc` is unchanged in the cycle after the stall.
- `halt` in cycle N: `halted` = 1 from N+1.
- `resume` in cycle N: `fetch_valid` = 1 in N+1.
- `rst` mid-FLUSH or mid-HALT: state returns to the reset values on the next edge.

## Configuration
- `PC_SEQ_PERF_EN` defined:
  - Adds outputs `perf_redirects` out 32 and `perf_stall_cycles` out 32.
  - `perf_redirects` increments on each accepted redirect.
  - `perf_stall_cycles` increments on each RUN cycle with `stall` and no redirect.
  - Both saturate at 32'hFFFF_FFFF and clear on `rst`.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `pc_seq_pkg`:
  - `PC_W` = 36.
  - `bj_e` enum: BJ_NONE = 2'b00, BJ_JUMP = 2'b01, BJ_BRANCH = 2'b10.
  - `seq_state_e` enum: RUN, FLUSH, HALT.
- Optional sub-module `pc_seq_perf`: the two saturating counters, instantiated only under `PC_SEQ_PERF_EN`.

## Test plan
- Reset with `RESET_PC` = 36'h100, no stimulus -> `fetch_pc` = 100, 101, 102 on consecutive cycles, `fetch_valid` = 1.
- Jump at cycle N: `ex_branch_jump` = 01, `ex_pc` = 36'h104, `ex_target` = 36'h200 -> `flush` = 1 for N+1 and N+2, valid fetch of 36'h200 at N+3.
- Not-taken branch: `ex_branch_jump` = 10, `ex_target` = `ex_pc` -> no flush, sequential fetch continues.
- `stall` held 3 cycles at `fetch_pc` = 36'h110 -> `fetch_pc` stays 36'h110 with `fetch_valid` = 0, then 36'h111 after release. Same-cycle redirect beats stall.
- Halt while an older redirect arrives the next cycle -> HALT is exited into FLUSH with the target loaded. Separately: halt, then resume 5 cycles later -> fetch resumes at the held PC.
- `fetch_pc` = 36'hF_FFFF_FFFF unstalled -> wraps to 0. With `PC_SEQ_PERF_EN`, force `perf_redirects` to 32'hFFFF_FFFF and apply a redirect -> the value holds at 32'hFFFF_FFFF.
